refill_line_buffer: RTL
=======================

Name: refill_line_buffer

Overview:
- Cache-miss refill stage that sits directly downstream of the miss/stall logic and upstream of the cache data array.
- On a miss, it requests a line from memory and accepts the line as a byte stream, one byte per valid beat.
- It assembles the bytes into a full cache line, writes the line to the data array with a single-cycle strobe, and holds the pipeline stall for the whole refill.

Parameters:
- LINE_BYTES, 32, bytes per cache line; must be a power of two, >= 2.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- miss  in  1  tag-compare miss indication; sampled only in IDLE.
- missAddr  in  ADDR_W  byte address of the missing access; sampled with miss.
- memReq  out  1  one-cycle request pulse to memory.
- memAddr  out  ADDR_W  line-aligned request address; valid while memReq=1 and held until the next request.
- memValid  in  1  memory byte beat valid.
- memData  in  8  memory byte beat.
- byteSel  out  LINE_BYTES  one-hot lane for the next expected byte; all zero outside FILL.
- lineWrite  out  1  one-cycle write strobe to the cache data array.
- lineAddr  out  ADDR_W  line-aligned address for lineWrite; equals memAddr.
- lineData  out  8*LINE_BYTES  assembled line; byte k occupies bits [8k+7:8k].
- stall  out  1  pipeline stall; high for the entire refill.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, byte counter=0, all outputs 0, lineData=0.
- Reset asserted mid-refill aborts the refill: no lineWrite is issued and partial data is discarded.
- The byte counter is $clog2(LINE_BYTES) bits wide.
- memAddr = missAddr with the low $clog2(LINE_BYTES) bits forced to 0.
- IDLE:
  - stall=0.
  - When miss=1 at a posedge: latch memAddr, clear the counter, go to REQ.
- REQ (exactly one cycle):
  - memReq=1, stall=1.
  - Then go to FILL.
- FILL:
  - stall=1; byteSel = one-hot of the counter.
  - On a posedge with memValid=1: write memData into lane[counter] of lineData.
  - If counter == LINE_BYTES-1, go to WRITE; otherwise counter+1.
  - memValid=0 means wait; there is no timeout.
- WRITE (exactly one cycle):
  - lineWrite=1, stall=1; lineData and lineAddr are stable.
  - Then go to IDLE, with stall=0 in the following cycle.
- Ignored inputs:
  - miss outside IDLE is ignored; any new miss is re-presented by upstream after stall drops.
  - memValid outside FILL is ignored; no byte is written.
- Latency:
  - Miss sampled at edge N gives memReq high in cycle N+1.
  - The first byte can be accepted at edge N+2.
  - With back-to-back beats, lineWrite is high in cycle N+2+LINE_BYTES.
  - stall is high from cycle N+1 through the lineWrite cycle; minimum refill is LINE_BYTES+2 stalled cycles.
- Consecutive refills: miss=1 held continuously starts a new refill in the cycle after returning to IDLE. One stall-low cycle between refills is required.
- lineData holds its value after WRITE until overwritten by the next fill, and is not cleared between refills.
- The counter wraps naturally at LINE_BYTES, but the FSM leaves FILL before wrap, so no wrap occurs in FILL.

Decomposition:
- Shared package refill_pkg holds:
  - State enum {IDLE, REQ, FILL, WRITE}, 2 bits.
  - LINE_BYTES and ADDR_W defaults.
  - An OFFSET_W = $clog2(LINE_BYTES) localparam.
- One sub-module, refill_byte_decoder: counter to one-hot byteSel, with an enable forcing all-zero. It generalises the existing 5-to-32 decoder to LINE_BYTES.
- FSM and line register stay in the top module.

Test Plan:
- Reset: assert reset 2 cycles mid-FILL after 10 bytes -> stall=0, lineWrite never fires, byteSel=0, lineData=0, next miss restarts at lane 0.
- Basic refill:
  - Stimulus: miss=1 with missAddr=0x0000_1234, then 32 back-to-back bytes 0x00..0x1F.
  - Response: memReq one cycle with memAddr=0x0000_1220; lineWrite exactly once at cycle N+34 with lineAddr=0x0000_1220 and lineData byte k = k.
  - stall is high for 34 cycles.
- Gapped beats:
  - Stimulus: memValid toggles 1/0 each cycle, data 0xA0+k.
  - Response: byteSel advances only on valid beats; lineWrite after 64 FILL cycles; lineData byte k = 0xA0+k.
- Ignored inputs: miss pulses during FILL and memValid=1 during IDLE/REQ -> no second memReq, no lane written, final line unchanged from scenario 2 values.
- Back-to-back:
  - Stimulus: miss held high across two refills, second address 0x0000_2000.
  - Response: exactly one stall-low cycle between refills; second memAddr=0x0000_2000; both lineWrites are correct.
- byteSel check: during FILL, byteSel equals 1<<k before byte k is accepted (k=0..31), and equals 0 in IDLE/REQ/WRITE.

Source files
------------

// File: rtl/refill_pkg.sv
// Shared types and default sizing for the cache-miss refill line buffer.
package refill_pkg;

  localparam int unsigned LINE_BYTES = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned OFFSET_W   = $clog2(LINE_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FILL  = 2'd2,
    WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/refill_byte_decoder.sv
// Byte counter to one-hot lane select; enable low forces all lanes off.
module refill_byte_decoder #(
  parameter int unsigned N = 32,
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] idx_i,
  input  logic         en_i,
  output logic [N-1:0] sel_o
);

  always_comb begin
    sel_o = '0;
    if (en_i) begin
      sel_o = N'(1) << idx_i;
    end
  end

endmodule

// File: rtl/refill_line_buffer.sv
// Cache-miss refill: requests a line, assembles a byte stream into it and
// writes it to the data array with a one-cycle strobe while stalling the pipe.
module refill_line_buffer #(
  parameter int unsigned LINE_BYTES = refill_pkg::LINE_BYTES,
  parameter int unsigned ADDR_W     = refill_pkg::ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    miss,
  input  logic [ADDR_W-1:0]       missAddr,
  output logic                    memReq,
  output logic [ADDR_W-1:0]       memAddr,
  input  logic                    memValid,
  input  logic [7:0]              memData,
  output logic [LINE_BYTES-1:0]   byteSel,
  output logic                    lineWrite,
  output logic [ADDR_W-1:0]       lineAddr,
  output logic [8*LINE_BYTES-1:0] lineData,
  output logic                    stall
);

  import refill_pkg::*;

  localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
  localparam int unsigned LINE_W = 8 * LINE_BYTES;
  localparam logic [OFF_W-1:0]  LAST_IDX    = OFF_W'(LINE_BYTES - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK  = ~ADDR_W'(LINE_BYTES - 1);

  state_e              state_q, state_d;
  logic [OFF_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [LINE_BYTES-1:0] sel_q, sel_d;
  logic                req_q, wr_q, stall_q;

  // Next-state, counter, address latch and lane write.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        if (miss) begin
          addr_d  = missAddr & ALIGN_MASK;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: state_d = FILL;
      FILL: begin
        if (memValid) begin
          line_d[{cnt_q, 3'b000} +: 8] = memData;
          if (cnt_q == LAST_IDX) begin
            state_d = WRITE;
          end else begin
            cnt_d = cnt_q + OFF_W'(1);
          end
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane select is decoded from next state so it registers alongside it.
  refill_byte_decoder #(
    .N (LINE_BYTES),
    .W (OFF_W)
  ) u_byte_decoder (
    .idx_i (cnt_d),
    .en_i  (state_d == FILL),
    .sel_o (sel_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      sel_q   <= '0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      sel_q   <= sel_d;
      req_q   <= (state_d == REQ);
      wr_q    <= (state_d == WRITE);
      stall_q <= (state_d != IDLE);
    end
  end

  assign memReq    = req_q;
  assign memAddr   = addr_q;
  assign lineAddr  = addr_q;
  assign lineWrite = wr_q;
  assign lineData  = line_q;
  assign byteSel   = sel_q;
  assign stall     = stall_q;

endmodule
